// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared types and helpers for the data-memory controller:
//                FSM state encoding, word-index width helper and the
//                fault-cause codes used when classifying rejected requests.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  // Fault causes; a rejected request may match more than one.
  localparam int FAULT_MISALIGNED = 0;
  localparam int FAULT_RANGE      = 1;
  localparam int FAULT_CONFLICT   = 2;

  // Word-index width for a DEPTH-word array (never narrower than one bit).
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_array
//  Description : DEPTH x N storage for the data-memory controller.
//                Synchronous write, combinational read, synchronous clear.
//  Ports       : clk     - clock
//                reset   - synchronous active-low clear of every word
//                we_i    - write enable
//                waddr_i - write word index
//                wdata_i - write data
//                raddr_i - read word index
//                rdata_o - read data (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_array #(
  parameter int N     = 64,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [N-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [N-1:0]  rdata_o
);

  logic [N-1:0] mem_q [DEPTH];

  // Clear has priority, so a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_ctrl
//  Description : Multi-cycle doubleword data-memory controller. Accepts one
//                load or store in IDLE, stalls the pipeline for LATENCY
//                cycles, commits on entry to DONE and strobes done.
//                Misaligned, out-of-range and conflicting requests are
//                rejected combinationally with fault.
//  Ports       : clk       - clock
//                reset     - synchronous active-low reset
//                address   - byte address (ALU result)
//                writeData - store data
//                memRead   - load request
//                memWrite  - store request
//                readData  - load result, holds last value
//                busy      - stall request
//                done      - one-cycle completion strobe
//                fault     - request rejected (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_ctrl #(
  parameter int N       = 64,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] address,
  input  logic [N-1:0] writeData,
  input  logic         memRead,
  input  logic         memWrite,
  output logic [N-1:0] readData,
  output logic         busy,
  output logic         done,
  output logic         fault
);

  import dmem_pkg::*;

  localparam int AW = idx_width(DEPTH);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 1) ? (LATENCY - 2) : 0);
  // One extra bit so the limit itself is representable even when
  // DEPTH*8 == 2**N; the comparison then covers the full address.
  localparam logic [N:0] LIMIT = (N+1)'(DEPTH * 8);

  dmem_state_t   state_q;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] idx_q;
  logic [N-1:0]  data_q;
  logic          wr_q;
  logic [N-1:0]  readData_q;

  logic          req, bad, accept, commit;
  logic [AW-1:0] acc_idx_d;
  logic [N-1:0]  acc_data_d;
  logic          acc_wr_d;
  logic [N-1:0]  arr_rdata;

  assign req    = memRead | memWrite;
  assign bad    = (|address[2:0]) | ({1'b0, address} >= LIMIT) | (memRead & memWrite);
  assign accept = (state_q == IDLE) & req & ~bad;

  // With LATENCY == 1 the commit happens on the acceptance edge itself,
  // before the latches hold the request, so the access path is muxed
  // between the live inputs (IDLE) and the latched copy (WAIT).
  assign commit     = ((state_q == WAIT) && (cnt_q == '0)) || ((LATENCY == 1) && accept);
  assign acc_idx_d  = (state_q == IDLE) ? address[AW+2:3] : idx_q;
  assign acc_data_d = (state_q == IDLE) ? writeData : data_q;
  assign acc_wr_d   = (state_q == IDLE) ? memWrite : wr_q;

  dmem_array #(
    .N     (N),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .we_i    (reset & commit & acc_wr_d),
    .waddr_i (acc_idx_d),
    .wdata_i (acc_data_d),
    .raddr_i (acc_idx_d),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      wr_q       <= 1'b0;
      readData_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            idx_q  <= address[AW+2:3];
            data_q <= writeData;
            wr_q   <= memWrite;
            if (LATENCY == 1) begin
              state_q <= DONE;
              if (!memWrite) readData_q <= arr_rdata;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= DONE;
            if (!wr_q) readData_q <= arr_rdata;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign readData = readData_q;
  assign busy     = reset & ((state_q == WAIT) | accept);
  assign done     = reset & (state_q == DONE);
  assign fault    = reset & (state_q == IDLE) & req & bad;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_ctrl
//  Description : Directed self-checking bench for dmem_ctrl. Two instances
//                share the stimulus: LATENCY=3 (main) and LATENCY=1, each
//                enabled onto the request lines by its own select bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_ctrl;

  logic        clk;
  logic        reset;
  logic [63:0] address;
  logic [63:0] writeData;
  logic        memRead;
  logic        memWrite;
  logic        en3, en1, cur;

  logic        memRead3, memWrite3, memRead1, memWrite1;
  logic [63:0] readData3, readData1;
  logic        busy3, done3, fault3, busy1, done1, fault1;
  logic [63:0] obs_rd;
  logic        obs_busy, obs_done, obs_fault;

  int n_checks = 0;
  int n_fail   = 0;

  assign memRead3  = memRead  & en3;
  assign memWrite3 = memWrite & en3;
  assign memRead1  = memRead  & en1;
  assign memWrite1 = memWrite & en1;

  assign obs_rd    = cur ? readData1 : readData3;
  assign obs_busy  = cur ? busy1     : busy3;
  assign obs_done  = cur ? done1     : done3;
  assign obs_fault = cur ? fault1    : fault3;

  dmem_ctrl #(.N(64), .DEPTH(64), .LATENCY(3)) u_dut3 (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .writeData (writeData),
    .memRead   (memRead3),
    .memWrite  (memWrite3),
    .readData  (readData3),
    .busy      (busy3),
    .done      (done3),
    .fault     (fault3)
  );

  dmem_ctrl #(.N(64), .DEPTH(64), .LATENCY(1)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .writeData (writeData),
    .memRead   (memRead1),
    .memWrite  (memWrite1),
    .readData  (readData1),
    .busy      (busy1),
    .done      (done1),
    .fault     (fault1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    address   = '0;
    writeData = '0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
  endtask

  // One access on the selected instance. Counts busy cycles up to the done
  // strobe (bounded). With scramble set, the request lines are driven with
  // unrelated traffic for the WAIT/DONE cycles, which must be ignored.
  task automatic access(input string tag, input bit sel, input logic rd, input logic wr,
                        input logic [63:0] a, input logic [63:0] d, input bit scramble,
                        input int exp_busy, input bit chk_rd, input logic [63:0] exp_rd);
    int nb;
    bit gd;
    nb = 0;
    gd = 1'b0;
    @(negedge clk);
    cur = sel; en3 = ~sel; en1 = sel;
    address = a; writeData = d; memRead = rd; memWrite = wr;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (scramble && i > 0) chk({tag, "_fault_ignored"}, {63'd0, obs_fault}, 64'd0);
      if (obs_done) begin
        gd = 1'b1;
        chk({tag, "_busy_in_done"}, {63'd0, obs_busy}, 64'd0);
        break;
      end
      if (obs_busy) nb++;
      @(negedge clk);
      if (scramble) begin
        if (i % 2 == 0) begin
          address = 64'h21; memRead = 1'b1; memWrite = 1'b1;
        end else begin
          address = 64'h20; writeData = 64'h1111; memRead = 1'b0; memWrite = 1'b1;
        end
      end else begin
        memRead = 1'b0; memWrite = 1'b0;
      end
    end
    clear_inputs();
    chk({tag, "_busy_cycles"}, 64'(nb), 64'(exp_busy));
    chk({tag, "_done"}, {63'd0, gd}, 64'd1);
    if (chk_rd) chk({tag, "_readData"}, obs_rd, exp_rd);
  endtask

  // A rejected request on the LATENCY=3 instance: fault with no busy in the
  // same cycle, and the controller is still idle the cycle after.
  task automatic bad_req(input string tag, input logic rd, input logic wr, input logic [63:0] a);
    @(negedge clk);
    cur = 1'b0; en3 = 1'b1; en1 = 1'b0;
    address = a; writeData = 64'h5555_5555_5555_5555; memRead = rd; memWrite = wr;
    #1;
    chk({tag, "_fault"}, {63'd0, fault3}, 64'd1);
    chk({tag, "_busy"}, {63'd0, busy3}, 64'd0);
    @(negedge clk);
    clear_inputs();
    #1;
    chk({tag, "_idle_busy"}, {63'd0, busy3}, 64'd0);
    chk({tag, "_idle_done"}, {63'd0, done3}, 64'd0);
  endtask

  initial begin
    cur = 1'b0; en3 = 1'b1; en1 = 1'b0;
    clear_inputs();
    reset = 1'b0;
    memRead = 1'b1;   // request held during reset must not raise busy
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("rst_busy", {63'd0, busy3}, 64'd0);
      chk("rst_fault", {63'd0, fault3}, 64'd0);
      chk("rst_done", {63'd0, done3}, 64'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    #1;
    chk("rst_readData", readData3, 64'd0);

    access("ld0", 1'b0, 1'b1, 1'b0, 64'h0, 64'h0, 1'b0, 3, 1'b1, 64'h0);
    access("st18", 1'b0, 1'b0, 1'b1, 64'h18, 64'hDEADBEEF_CAFEF00D, 1'b0, 3, 1'b1, 64'h0);
    access("ld18", 1'b0, 1'b1, 1'b0, 64'h18, 64'h0, 1'b0, 3, 1'b1, 64'hDEADBEEF_CAFEF00D);

    bad_req("mis1c", 1'b1, 1'b0, 64'h1C);
    bad_req("rng200", 1'b1, 1'b0, 64'h200);
    bad_req("conf08", 1'b1, 1'b1, 64'h8);
    bad_req("rng_hi", 1'b0, 1'b1, 64'h8000_0000_0000_0018);
    access("ld08_clean", 1'b0, 1'b1, 1'b0, 64'h8, 64'h0, 1'b0, 3, 1'b1, 64'h0);
    access("ld18_kept", 1'b0, 1'b1, 1'b0, 64'h18, 64'h0, 1'b0, 3, 1'b1, 64'hDEADBEEF_CAFEF00D);

    access("ld18_scr", 1'b0, 1'b1, 1'b0, 64'h18, 64'h0, 1'b1, 3, 1'b1, 64'hDEADBEEF_CAFEF00D);
    access("ld20_clean", 1'b0, 1'b1, 1'b0, 64'h20, 64'h0, 1'b0, 3, 1'b1, 64'h0);

    access("ld18_pre", 1'b0, 1'b1, 1'b0, 64'h18, 64'h0, 1'b0, 3, 1'b1, 64'hDEADBEEF_CAFEF00D);
    // A store leaves readData at the previous load result.
    access("st1f8", 1'b0, 1'b0, 1'b1, 64'h1F8, 64'h0123_4567_89AB_CDEF, 1'b0, 3, 1'b1,
           64'hDEADBEEF_CAFEF00D);
    access("ld1f8", 1'b0, 1'b1, 1'b0, 64'h1F8, 64'h0, 1'b0, 3, 1'b1, 64'h0123_4567_89AB_CDEF);
    bad_req("rng_last_plus8", 1'b1, 1'b0, 64'h1F8 + 64'h8);

    access("l1_st08", 1'b1, 1'b0, 1'b1, 64'h8, 64'hA5A5_0000_FFFF_1234, 1'b0, 1, 1'b1, 64'h0);
    access("l1_ld08", 1'b1, 1'b1, 1'b0, 64'h8, 64'h0, 1'b0, 1, 1'b1, 64'hA5A5_0000_FFFF_1234);

    // Store to 0x10, reset asserted in its second busy cycle.
    @(negedge clk);
    cur = 1'b0; en3 = 1'b1; en1 = 1'b0;
    address = 64'h10; writeData = 64'h77; memWrite = 1'b1;
    @(negedge clk);
    clear_inputs();
    #1;
    chk("abort_busy_wait", {63'd0, busy3}, 64'd1);
    reset = 1'b0;
    #1;
    chk("abort_busy_forced", {63'd0, busy3}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_readData", readData3, 64'd0);
    access("abort_ld10", 1'b0, 1'b1, 1'b0, 64'h10, 64'h0, 1'b0, 3, 1'b1, 64'h0);
    access("abort_ld1f8", 1'b0, 1'b1, 1'b0, 64'h1F8, 64'h0, 1'b0, 3, 1'b1, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
